// File: rtl/fpu_addsub_pipe.sv
// Three-stage pipelined IEEE-754-style floating-point adder/subtractor with a global stall.
// Optional macro FPU_RNE_EN selects round-to-nearest-even; otherwise results truncate toward zero.
module fpu_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [EXP_W+MAN_W:0]   op_a_i,
  input  logic [EXP_W+MAN_W:0]   op_b_i,
  input  logic [1:0]             fpu_op_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W+MAN_W:0]   fpu_data_o,
  output logic [3:0]             flags_o
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int SW = MAN_W + 5;  // aligned sum with carry-out
  localparam int EW = EXP_W + 2;  // signed working exponent
  localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAX   = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPU_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif
  localparam logic [W-2:0] OVF_MAG = RNE ? {EXP_ONES, {MAN_W{1'b0}}} : {EXP_MAX, {MAN_W{1'b1}}};

  function automatic logic [EXP_W-1:0] lzc(input logic [MW-1:0] m);
    lzc = EXP_W'(MW);
    for (int i = 0; i < MW; i++) begin
      if (m[i]) lzc = EXP_W'(MW - 1 - i);
    end
  endfunction

  // Stage 1 combinational
  logic             a_sign, b_sign, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, sml_exp, d_exp, shamt;
  logic [MAN_W-1:0] a_frac, b_frac, big_frac, sml_frac;
  logic [MW-1:0]    m_sml, lost;
  logic             spec_d, sign_d, sub_d, bneg_d;
  logic [W-1:0]     spec_res_d;
  logic [3:0]       spec_flg_d;
  logic [EXP_W-1:0] exp_d;
  logic [MW-1:0]    ma_d, mb_d;
  // Stage registers
  logic             s1_valid_q, s1_spec_q, s1_sign_q, s1_sub_q, s1_bneg_q;
  logic [W-1:0]     s1_spec_res_q;
  logic [3:0]       s1_spec_flg_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MW-1:0]    s1_ma_q, s1_mb_q;
  logic             s2_valid_q, s2_spec_q, s2_sign_q, s2_bneg_q;
  logic [W-1:0]     s2_spec_res_q;
  logic [3:0]       s2_spec_flg_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [SW-1:0]    s2_sum_q, sum_d;
  logic             valid_q;
  logic [W-1:0]     data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  // Stage 3 combinational
  logic [EXP_W-1:0]        lz;
  logic [MW-1:0]           norm;
  logic signed [EW-1:0]    exp_n, exp_r;
  logic                    rnd_up, inexact;
  logic [MAN_W+1:0]        man_r;
  logic [MAN_W-1:0]        frac_r;

  assign ready_o    = !(valid_q && !ready_i);
  assign valid_o    = valid_q;
  assign fpu_data_o = data_q;
  assign flags_o    = flags_q;

  // S1: unpack, classify specials, order by magnitude and align the smaller operand.
  always_comb begin
    a_sign = op_a_i[W-1];
    b_sign = op_b_i[W-1] ^ fpu_op_i[0];
    a_exp  = op_a_i[W-2:MAN_W];
    b_exp  = op_b_i[W-2:MAN_W];
    a_nan  = (a_exp == EXP_ONES) && (op_a_i[MAN_W-1:0] != {MAN_W{1'b0}});
    b_nan  = (b_exp == EXP_ONES) && (op_b_i[MAN_W-1:0] != {MAN_W{1'b0}});
    a_snan = a_nan && !op_a_i[MAN_W-1];
    b_snan = b_nan && !op_b_i[MAN_W-1];
    a_inf  = (a_exp == EXP_ONES) && (op_a_i[MAN_W-1:0] == {MAN_W{1'b0}});
    b_inf  = (b_exp == EXP_ONES) && (op_b_i[MAN_W-1:0] == {MAN_W{1'b0}});
    // subnormal operands behave as signed zero
    a_frac = (a_exp == {EXP_W{1'b0}}) ? {MAN_W{1'b0}} : op_a_i[MAN_W-1:0];
    b_frac = (b_exp == {EXP_W{1'b0}}) ? {MAN_W{1'b0}} : op_b_i[MAN_W-1:0];
    swap     = {b_exp, b_frac} > {a_exp, a_frac};
    big_exp  = swap ? b_exp  : a_exp;
    sml_exp  = swap ? a_exp  : b_exp;
    big_frac = swap ? b_frac : a_frac;
    sml_frac = swap ? a_frac : b_frac;
    d_exp    = big_exp - sml_exp;
    shamt    = (d_exp > MAX_SHIFT) ? MAX_SHIFT : d_exp;
    m_sml    = {(sml_exp != {EXP_W{1'b0}}), sml_frac, 3'b000};
    lost     = m_sml & ~({MW{1'b1}} << shamt);
    mb_d     = m_sml >> shamt;
    mb_d[0]  = mb_d[0] | (|lost);
    ma_d     = {(big_exp != {EXP_W{1'b0}}), big_frac, 3'b000};
    exp_d    = big_exp;
    sign_d   = swap ? b_sign : a_sign;
    sub_d    = a_sign ^ b_sign;
    bneg_d   = a_sign & b_sign;
    spec_d     = 1'b1;
    spec_res_d = QNAN;
    spec_flg_d = 4'b0000;
    if (fpu_op_i[1]) begin
      spec_res_d = op_a_i;
    end else if (a_nan || b_nan) begin
      spec_flg_d = {(a_snan || b_snan), 3'b000};
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      spec_flg_d = 4'b1000;
    end else if (a_inf) begin
      spec_res_d = op_a_i;
    end else if (b_inf) begin
      spec_res_d = {b_sign, op_b_i[W-2:0]};
    end else begin
      spec_d = 1'b0;
    end
  end

  // S2: magnitude add or subtract; operand order guarantees a non-negative difference.
  always_comb begin
    if (s1_sub_q) begin
      sum_d = {1'b0, s1_ma_q} - {1'b0, s1_mb_q};
    end else begin
      sum_d = {1'b0, s1_ma_q} + {1'b0, s1_mb_q};
    end
  end

  // S3: normalise, round, detect overflow/underflow and pack.
  always_comb begin
    lz = {EXP_W{1'b0}};
    if (s2_sum_q[SW-1]) begin
      norm  = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = {2'b00, s2_exp_q} + {{(EW-1){1'b0}}, 1'b1};
    end else begin
      lz    = lzc(s2_sum_q[MW-1:0]);
      norm  = s2_sum_q[MW-1:0] << lz;
      exp_n = {2'b00, s2_exp_q} - {2'b00, lz};
    end
    inexact = |norm[2:0];
    rnd_up  = RNE & norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r   = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    exp_r   = exp_n + {{(EW-1){1'b0}}, man_r[MAN_W+1]};
    frac_r  = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    if (s2_spec_q) begin
      data_d  = s2_spec_res_q;
      flags_d = s2_spec_flg_q;
    end else if (s2_sum_q == {SW{1'b0}}) begin
      data_d  = {s2_bneg_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (exp_n <= $signed({EW{1'b0}})) begin
      data_d  = {s2_sign_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (exp_r >= $signed({2'b00, EXP_ONES})) begin
      data_d  = {s2_sign_q, OVF_MAG};
      flags_d = 4'b0101;
    end else begin
      data_d  = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
      flags_d = {3'b000, inexact};
    end
  end

  // Pipeline registers; a stalled output freezes every stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q    <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_spec_res_q <= {W{1'b0}};
      s1_spec_flg_q <= 4'b0000;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_bneg_q     <= 1'b0;
      s1_exp_q      <= {EXP_W{1'b0}};
      s1_ma_q       <= {MW{1'b0}};
      s1_mb_q       <= {MW{1'b0}};
      s2_valid_q    <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= {W{1'b0}};
      s2_spec_flg_q <= 4'b0000;
      s2_sign_q     <= 1'b0;
      s2_bneg_q     <= 1'b0;
      s2_exp_q      <= {EXP_W{1'b0}};
      s2_sum_q      <= {SW{1'b0}};
      valid_q       <= 1'b0;
      data_q        <= {W{1'b0}};
      flags_q       <= 4'b0000;
    end else if (ready_o) begin
      s1_valid_q    <= valid_i;
      s1_spec_q     <= spec_d;
      s1_spec_res_q <= spec_res_d;
      s1_spec_flg_q <= spec_flg_d;
      s1_sign_q     <= sign_d;
      s1_sub_q      <= sub_d;
      s1_bneg_q     <= bneg_d;
      s1_exp_q      <= exp_d;
      s1_ma_q       <= ma_d;
      s1_mb_q       <= mb_d;
      s2_valid_q    <= s1_valid_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_spec_flg_q <= s1_spec_flg_q;
      s2_sign_q     <= s1_sign_q;
      s2_bneg_q     <= s1_bneg_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= sum_d;
      valid_q       <= s2_valid_q;
      data_q        <= data_d;
      flags_q       <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed self-checking bench for fpu_addsub_pipe (single precision plus a half-precision instance).
module tb_fpu_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst_n, valid_i, ready_o, valid_o, ready_i;
  logic [31:0] op_a, op_b, data_o;
  logic [1:0]  op;
  logic [3:0]  flags_o;
  logic        h_valid_i, h_ready_o, h_valid_o;
  logic [15:0] h_a, h_b, h_data;
  logic [1:0]  h_op;
  logic [3:0]  h_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int n_spur   = 0;
  int n_pop    = 0;
  int cyc      = 0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic [3:0]  flags;
    int          t;
    bit          lc;
  } exp_t;
  exp_t q[$];

  fpu_addsub_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .op_a_i(op_a), .op_b_i(op_b), .fpu_op_i(op), .valid_o(valid_o),
    .ready_i(ready_i), .fpu_data_o(data_o), .flags_o(flags_o)
  );

  fpu_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(h_valid_i), .ready_o(h_ready_o),
    .op_a_i(h_a), .op_b_i(h_b), .fpu_op_i(h_op), .valid_o(h_valid_o),
    .ready_i(1'b1), .fpu_data_o(h_data), .flags_o(h_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Result monitor: compares each presented result with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (q.size() == 0) begin
        n_spur++;
      end else begin
        check_eq({q[0].name, "_data"}, data_o, q[0].data);
        check_eq({q[0].name, "_flags"}, 32'(flags_o), 32'(q[0].flags));
        if (q[0].lc) check_eq({q[0].name, "_latency"}, 32'(cyc - q[0].t), 32'd3);
        if (ready_i) begin
          void'(q.pop_front());
          n_pop++;
        end
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] o, input logic [31:0] ed, input logic [3:0] ef,
                       input bit lc);
    exp_t e;
    bit   acc;
    valid_i = 1'b1;
    op_a    = a;
    op_b    = b;
    op      = o;
    e.name  = name;
    e.data  = ed;
    e.flags = ef;
    e.lc    = lc;
    e.t     = 0;
    acc     = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = ready_o;
      e.t = cyc;
      @(posedge clk);
      #1;
    end
    check_eq({name, "_accepted"}, 32'(acc), 32'd1);
    if (acc) q.push_back(e);
  endtask

  task automatic drain();
    valid_i = 1'b0;
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
    #1;
    check_eq("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input logic [31:0] ed, input logic [3:0] ef);
    issue(name, a, b, o, ed, ef, 1'b1);
    drain();
  endtask

  logic [31:0] seq_a [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] seq_r [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

  initial begin
    int  pop0, t0;
    bit  hacc, found;
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_a = 32'h0; op_b = 32'h0; op = 2'b00;
    h_valid_i = 1'b0; h_a = 16'h0; h_b = 16'h0; h_op = 2'b00;
    #12;
    check_eq("rst_valid_o", 32'(valid_o), 32'd0);
    check_eq("rst_data", data_o, 32'h0);
    check_eq("rst_flags", 32'(flags_o), 32'd0);
    check_eq("rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_one("add_1p2",    32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, 4'h0);
    run_one("sub_5m5",    32'h40A00000, 32'h40A00000, 2'b01, 32'h00000000, 4'h0);
    run_one("inf_minf",   32'h7F800000, 32'hFF800000, 2'b00, 32'h7FC00000, 4'h8);
    run_one("tie_even",   32'h3F800000, 32'h33800000, 2'b00, 32'h3F800000, 4'h1);
`ifdef FPU_RNE_EN
    run_one("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F800000, 4'h5);
    run_one("round_up",   32'h3F800000, 32'h33C00000, 2'b00, 32'h3F800001, 4'h1);
`else
    run_one("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 2'b00, 32'h7F7FFFFF, 4'h5);
    run_one("round_up",   32'h3F800000, 32'h33C00000, 2'b00, 32'h3F800000, 4'h1);
`endif
    run_one("pass_10",    32'h7FA00000, 32'h3F800000, 2'b10, 32'h7FA00000, 4'h0);
    run_one("pass_11",    32'hC0490FDB, 32'h7F800001, 2'b11, 32'hC0490FDB, 4'h0);
    run_one("snan_in",    32'h7F800001, 32'h3F800000, 2'b00, 32'h7FC00000, 4'h8);
    run_one("qnan_in",    32'h3F800000, 32'hFFC00001, 2'b00, 32'h7FC00000, 4'h0);
    run_one("neg_zeros",  32'h80000000, 32'h80000000, 2'b00, 32'h80000000, 4'h0);
    run_one("subnorm_in", 32'h3F800000, 32'h00400000, 2'b00, 32'h3F800000, 4'h0);
    run_one("uflow",      32'h00800001, 32'h00800000, 2'b01, 32'h00000000, 4'h3);
    run_one("inf_plus",   32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 4'h0);
    run_one("minus_inf",  32'h3F800000, 32'h7F800000, 2'b01, 32'hFF800000, 4'h0);
    run_one("sub_3m1",    32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, 4'h0);
    run_one("neg_mix",    32'hBFC00000, 32'h3F000000, 2'b00, 32'hBF800000, 4'h0);
    run_one("cancel",     32'hBF800000, 32'h3F800000, 2'b00, 32'h00000000, 4'h0);

    // Back-to-back stream with a 4-cycle downstream stall in the middle.
    pop0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) issue($sformatf("stream%0d", i), seq_a[i], 32'h3F800000, 2'b00, seq_r[i], 4'h0, 1'b0);
        valid_i = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (4) begin
          @(negedge clk);
          check_eq("stall_ready_o", 32'(ready_o), 32'd0);
          @(posedge clk);
          #1;
        end
        ready_i = 1'b1;
      end
    join
    drain();
    check_eq("stream_count", 32'(n_pop - pop0), 32'd8);

    // Reset with three operations in flight.
    valid_i = 1'b1; op_a = 32'h3F800000; op_b = 32'h40000000; op = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_valid_o", 32'(valid_o), 32'd1);
    rst_n = 1'b0;
    valid_i = 1'b0;
    #1;
    check_eq("async_rst_valid_o", 32'(valid_o), 32'd0);
    check_eq("async_rst_data", data_o, 32'h0);
    check_eq("async_rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    run_one("post_rst", 32'h40400000, 32'h3F800000, 2'b00, 32'h40800000, 4'h0);

    // Half-precision parameter set.
    h_valid_i = 1'b1; h_a = 16'h3C00; h_b = 16'h3C00; h_op = 2'b00;
    @(negedge clk);
    hacc = h_ready_o;
    t0 = cyc;
    @(posedge clk); #1;
    h_valid_i = 1'b0;
    check_eq("h_accept", 32'(hacc), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (h_valid_o) begin
        found = 1'b1;
        check_eq("h_data", 32'(h_data), 32'h4000);
        check_eq("h_flags", 32'(h_flags), 32'd0);
        check_eq("h_latency", 32'(cyc - t0), 32'd3);
      end
    end
    check_eq("h_result_seen", 32'(found), 32'd1);

    check_eq("spurious_results", 32'(n_spur), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
